// File: rtl/recv_buffer.sv
// recv_buffer: receive-side buffering between the Rdma engine and the PCIe slave port.
//
// The Rdma engine pushes WIDTH-bit beats tagged with a 2-bit channel into four
// independent DEPTH-entry FIFOs. The PCIe side drains them through an on-chip-memory
// style slave port, where reading a channel's data window pops that channel's head
// entry. A status word and clear-on-write sticky error bits live in a second window.
//
// Ports:
//   clock, reset            single clock, asynchronous active-low reset
//   address                 [9] window select (0 data, 1 status), [4:3] data channel
//   clken, chipselect       slave access qualifiers
//   write, writedata        write strobe and data (status window only)
//   byteenable              only bit 0 is used
//   readdata                registered read data, latency 1
//   dataPush, dataChannel   Rdma push strobe and target channel
//   dataIn                  Rdma push data
//   fullArray, emptyArray   per-channel full / empty flags
//   dataAvail               any channel holds data
module recv_buffer #(
   parameter int unsigned WIDTH = 256,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CW    = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [9:0]           address,
   input  logic                 clken,
   input  logic                 chipselect,
   input  logic                 write,
   input  logic [WIDTH-1:0]     writedata,
   input  logic [WIDTH/8-1:0]   byteenable,
   output logic [WIDTH-1:0]     readdata,
   input  logic                 dataPush,
   input  logic [1:0]           dataChannel,
   input  logic [WIDTH-1:0]     dataIn,
   output logic [3:0]           fullArray,
   output logic [3:0]           emptyArray,
   output logic                 dataAvail
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [CW-1:0]    count_q [4];
   logic [CW-1:0]    count_d [4];
   logic [PW-1:0]    wptr_q  [4];
   logic [PW-1:0]    rptr_q  [4];
   logic [3:0]       overrun_q, overrun_d;
   logic [3:0]       underrun_q, underrun_d;
   logic [WIDTH-1:0] mem [4][DEPTH];

   logic             acc, rd, wr;
   logic             rd_data, rd_stat, st_wr;
   logic [1:0]       rch;
   logic             push_ok, pop_ok;
   logic [3:0]       push_sel, pop_sel;
   logic [3:0]       ovr_set, udr_set;
   logic [3:0]       ovr_clr, udr_clr;
   logic [WIDTH-1:0] status;

   // Flags decode straight from the registered counts.
   always_comb begin
      for (int c = 0; c < 4; c++) begin
         emptyArray[c] = (count_q[c] == '0);
         fullArray[c]  = (count_q[c] == FULL_COUNT);
      end
   end

   assign dataAvail = ~&emptyArray;

   assign acc     = clken & chipselect;
   assign rd      = acc & ~write;
   assign wr      = acc & write;
   assign rd_data = rd & ~address[9];
   assign rd_stat = rd & address[9];
   assign st_wr   = wr & address[9] & byteenable[0];
   assign rch     = address[4:3];

   // Full/empty judged on pre-edge counts: no bypass between push and pop.
   assign push_ok = dataPush & ~fullArray[dataChannel];
   assign pop_ok  = rd_data & ~emptyArray[rch];

   assign ovr_clr = st_wr ? writedata[11:8]  : 4'h0;
   assign udr_clr = st_wr ? writedata[15:12] : 4'h0;

   always_comb begin
      push_sel = 4'h0;
      pop_sel  = 4'h0;
      ovr_set  = 4'h0;
      udr_set  = 4'h0;
      if (push_ok) begin
         push_sel[dataChannel] = 1'b1;
      end
      if (pop_ok) begin
         pop_sel[rch] = 1'b1;
      end
      if (dataPush && fullArray[dataChannel]) begin
         ovr_set[dataChannel] = 1'b1;
      end
      if (rd_data && emptyArray[rch]) begin
         udr_set[rch] = 1'b1;
      end
      for (int c = 0; c < 4; c++) begin
         count_d[c] = count_q[c] + CW'(push_sel[c]) - CW'(pop_sel[c]);
      end
      // A set in the same cycle as its clear wins.
      overrun_d  = (overrun_q & ~ovr_clr) | ovr_set;
      underrun_d = (underrun_q & ~udr_clr) | udr_set;
   end

   always_comb begin
      status        = '0;
      status[3:0]   = emptyArray;
      status[7:4]   = fullArray;
      status[11:8]  = overrun_q;
      status[15:12] = underrun_q;
      for (int c = 0; c < 4; c++) begin
         status[16 + 4*c +: 4] = 4'(count_q[c]);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < 4; c++) begin
            count_q[c] <= '0;
            wptr_q[c]  <= '0;
            rptr_q[c]  <= '0;
         end
         overrun_q  <= 4'h0;
         underrun_q <= 4'h0;
         readdata   <= '0;
      end else begin
         for (int c = 0; c < 4; c++) begin
            count_q[c] <= count_d[c];
            if (push_sel[c]) begin
               wptr_q[c] <= wptr_q[c] + PW'(1);
            end
            if (pop_sel[c]) begin
               rptr_q[c] <= rptr_q[c] + PW'(1);
            end
         end
         overrun_q  <= overrun_d;
         underrun_q <= underrun_d;
         if (rd_stat) begin
            readdata <= status;
         end else if (rd_data) begin
            readdata <= pop_ok ? mem[rch][rptr_q[rch]] : '0;
         end
      end
   end

   // Storage is not reset; the cleared pointers and counts make stale entries unreachable.
   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem[dataChannel][wptr_q[dataChannel]] <= dataIn;
      end
   end

   logic unused_bits;
   assign unused_bits = ^{address[8:5], address[2:0], writedata[WIDTH-1:16], writedata[7:0],
                          byteenable[WIDTH/8-1:1]};

endmodule

// File: tb/tb_recv_buffer.sv
module tb_recv_buffer;

   localparam int W = 256;

   logic           clock = 1'b0;
   logic           reset;
   logic [9:0]     address;
   logic           clken, chipselect, write;
   logic [W-1:0]   writedata;
   logic [W/8-1:0] byteenable;
   logic [W-1:0]   readdata;
   logic           dataPush;
   logic [1:0]     dataChannel;
   logic [W-1:0]   dataIn;
   logic [3:0]     fullArray, emptyArray;
   logic           dataAvail;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   recv_buffer #(.WIDTH(W), .DEPTH(8), .CW(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .address    (address),
      .clken      (clken),
      .chipselect (chipselect),
      .write      (write),
      .writedata  (writedata),
      .byteenable (byteenable),
      .readdata   (readdata),
      .dataPush   (dataPush),
      .dataChannel(dataChannel),
      .dataIn     (dataIn),
      .fullArray  (fullArray),
      .emptyArray (emptyArray),
      .dataAvail  (dataAvail)
   );

   typedef struct {
      logic         push;
      logic [1:0]   ch;
      logic [W-1:0] din;
      logic         rd;
      logic [9:0]   addr;
      logic         chk_rd;
      logic [W-1:0] exp_rd;
      logic [3:0]   exp_full;
      logic [3:0]   exp_empty;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [W-1:0] pat(input logic [31:0] tag);
      return {tag, ~tag, tag, ~tag, tag, ~tag, tag, ~tag};
   endfunction

   function automatic vec_t mk(input logic push, input logic [1:0] ch, input logic [W-1:0] din,
                               input logic rd, input logic [9:0] addr, input logic chk_rd,
                               input logic [W-1:0] exp_rd, input logic [3:0] exp_full,
                               input logic [3:0] exp_empty);
      vec_t v;
      v.push = push; v.ch = ch; v.din = din; v.rd = rd; v.addr = addr;
      v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_full = exp_full; v.exp_empty = exp_empty;
      return v;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic push, input logic [1:0] ch, input logic [W-1:0] din,
                        input logic rd, input logic wr, input logic [9:0] addr,
                        input logic [W-1:0] wd);
      dataPush    = push;
      dataChannel = ch;
      dataIn      = din;
      clken       = 1'b1;
      chipselect  = rd | wr;
      write       = wr;
      address     = addr;
      writedata   = wd;
      byteenable  = '1;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 2'd0, '0, 1'b0, 1'b0, 10'h000, '0);
   endtask

   task automatic push(input logic [1:0] ch, input logic [W-1:0] d);
      drive(1'b1, ch, d, 1'b0, 1'b0, 10'h000, '0);
      tick();
      idle();
   endtask

   task automatic pop_check(input string name, input logic [9:0] addr, input logic [W-1:0] exp);
      drive(1'b0, 2'd0, '0, 1'b1, 1'b0, addr, '0);
      tick();
      check(name, readdata, exp);
      idle();
   endtask

   task automatic status_check(input string name, input logic [31:0] exp);
      drive(1'b0, 2'd0, '0, 1'b1, 1'b0, 10'h200, '0);
      tick();
      check(name, readdata, W'(exp));
      idle();
   endtask

   task automatic status_write(input logic [W-1:0] wd);
      drive(1'b0, 2'd0, '0, 1'b0, 1'b1, 10'h200, wd);
      tick();
      idle();
   endtask

   initial begin
      logic [31:0] nxt_in, nxt_out;
      vec_t v;

      // ---------------- table: reset status, ch2 basic, ch1 overrun ----------------
      tbl.push_back(mk(0, 0, '0, 1, 10'h200, 1, W'(32'h0000_000F), 4'h0, 4'hF));
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(1, 2, pat(32'hA000 + i), 0, 10'h000, 0, '0, 4'h0, 4'b1011));
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(0, 0, '0, 1, 10'h010, 1, pat(32'hA000 + i), 4'h0,
                          (i == 2) ? 4'hF : 4'b1011));
      tbl.push_back(mk(0, 0, '0, 1, 10'h010, 1, '0, 4'h0, 4'hF));
      tbl.push_back(mk(0, 0, '0, 1, 10'h200, 1, W'(32'h0000_400F), 4'h0, 4'hF));
      for (int i = 0; i < 9; i++)
         tbl.push_back(mk(1, 1, pat(32'hD000 + i), 0, 10'h000, 0, '0,
                          (i >= 7) ? 4'b0010 : 4'h0, 4'b1101));
      tbl.push_back(mk(0, 0, '0, 1, 10'h200, 1, W'(32'h0080_422D), 4'b0010, 4'b1101));
      // alternate plain and don't-care-bit addresses for ch1
      for (int i = 0; i < 8; i++)
         tbl.push_back(mk(0, 0, '0, 1, (i % 2 == 0) ? 10'h008 : 10'h1EF, 1, pat(32'hD000 + i),
                          4'h0, (i == 7) ? 4'hF : 4'b1101));
      tbl.push_back(mk(0, 0, '0, 1, 10'h008, 1, '0, 4'h0, 4'hF));
      tbl.push_back(mk(0, 0, '0, 1, 10'h200, 1, W'(32'h0000_620F), 4'h0, 4'hF));

      // ---------------- reset ----------------
      reset = 1'b0;
      idle();
      tick();
      tick();
      check("reset_readdata", readdata, '0);
      check("reset_empty", W'(emptyArray), W'(4'hF));
      check("reset_full", W'(fullArray), W'(4'h0));
      check("reset_avail", W'(dataAvail), W'(1'b0));
      reset = 1'b1;

      foreach (tbl[i]) begin
         v = tbl[i];
         drive(v.push, v.ch, v.din, v.rd, 1'b0, v.addr, '0);
         tick();
         if (v.chk_rd) check($sformatf("vec%0d_readdata", i), readdata, v.exp_rd);
         check($sformatf("vec%0d_full", i), W'(fullArray), W'(v.exp_full));
         check($sformatf("vec%0d_empty", i), W'(emptyArray), W'(v.exp_empty));
         check($sformatf("vec%0d_avail", i), W'(dataAvail), W'(v.exp_empty != 4'hF));
      end
      idle();

      // ---------------- ch0 simultaneous push + pop ----------------
      for (int i = 0; i < 7; i++) push(2'd0, pat(32'hE000 + i));
      drive(1'b1, 2'd0, pat(32'hE007), 1'b1, 1'b0, 10'h000, '0);
      tick();
      check("pp7_readdata", readdata, pat(32'hE000));
      idle();
      status_check("pp7_status", 32'h0007_620E);
      push(2'd0, pat(32'hE008));
      check("fill8_full", W'(fullArray), W'(4'b0001));
      // clken low: no access taken, readdata holds
      drive(1'b0, 2'd0, '0, 1'b1, 1'b0, 10'h000, '0);
      clken = 1'b0;
      tick();
      check("clken_hold", readdata, W'(32'h0007_620E));
      check("clken_full", W'(fullArray), W'(4'b0001));
      drive(1'b1, 2'd0, pat(32'hE009), 1'b1, 1'b0, 10'h000, '0);
      tick();
      check("pp8_readdata", readdata, pat(32'hE001));
      check("pp8_full", W'(fullArray), W'(4'h0));
      idle();
      status_check("pp8_status", 32'h0007_630E);
      for (int i = 2; i < 9; i++) pop_check($sformatf("drain0_%0d", i), 10'h000, pat(32'hE000 + i));
      check("drain0_empty", W'(emptyArray), W'(4'hF));

      // ---------------- sticky clear ----------------
      status_write(W'(32'h0000_FF00));
      status_check("clear_status", 32'h0000_000F);
      drive(1'b0, 2'd0, '0, 1'b0, 1'b1, 10'h000, pat(32'h1234));
      tick();
      idle();
      check("data_write_ignored", W'(emptyArray), W'(4'hF));
      for (int i = 0; i < 8; i++) push(2'd1, pat(32'hF000 + i));
      drive(1'b1, 2'd1, pat(32'hF008), 1'b0, 1'b1, 10'h200, W'(32'h0000_FF00));
      tick();
      idle();
      status_check("set_wins_status", 32'h0080_022D);
      status_write(W'(32'h0000_FF00));
      status_check("reclear_status", 32'h0080_002D);
      for (int i = 0; i < 8; i++) pop_check($sformatf("drain1_%0d", i), 10'h008, pat(32'hF000 + i));

      // ---------------- ch3 laps across pointer wrap ----------------
      nxt_in  = 32'h3000;
      nxt_out = 32'h3000;
      for (int lap = 0; lap < 20; lap++) begin
         for (int k = 0; k < (lap % 8) + 1; k++) begin
            push(2'd3, pat(nxt_in));
            nxt_in++;
         end
         for (int k = 0; k < (lap % 8) + 1; k++) begin
            pop_check($sformatf("lap%0d_%0d", lap, k), 10'h018, pat(nxt_out));
            nxt_out++;
         end
      end
      check("laps_empty", W'(emptyArray), W'(4'hF));

      // ---------------- reset mid-stream ----------------
      for (int i = 0; i < 3; i++) push(2'd3, pat(32'h5000 + i));
      push(2'd0, pat(32'h6000));
      pop_check("pre_reset_pop", 10'h018, pat(32'h5000));
      #3;
      reset = 1'b0;
      #1;
      check("midreset_empty", W'(emptyArray), W'(4'hF));
      check("midreset_readdata", readdata, '0);
      check("midreset_full", W'(fullArray), W'(4'h0));
      check("midreset_avail", W'(dataAvail), W'(1'b0));
      tick();
      reset = 1'b1;
      status_check("post_reset_status", 32'h0000_000F);
      pop_check("post_reset_pop", 10'h018, '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/recv_buffer.md
Name: recv_buffer

Overview:
- Receive-direction counterpart of the PCIe send path.
- The Rdma engine pushes 256-bit beats, each tagged with a 2-bit channel, into four independent 8-deep FIFOs.
- The PCIe side drains them through an on-chip-memory style slave port. A read of a channel's data window pops that channel's head entry.
- A status word and clear-on-write sticky error bits sit in a separate address window.

Parameters:
- WIDTH, 256, data beat width in bits.
- DEPTH, 8, entries per channel FIFO; must be a power of 2.
- CW, 4, per-channel occupancy counter width; holds 0..DEPTH.

Ports:
- clock  in  1  single clock for both sides.
- reset  in  1  asynchronous, active-low reset.
- address  in  10  slave address; [9] selects window (0 = data, 1 = status); [4:3] selects channel in the data window.
- clken  in  1  slave clock enable; no access is taken when low.
- chipselect  in  1  slave select.
- write  in  1  1 = write access, 0 = read access.
- writedata  in  WIDTH  write data; only meaningful for the status window.
- byteenable  in  WIDTH/8  byte enables; only bit 0 is used.
- readdata  out  WIDTH  registered read data.
- dataPush  in  1  Rdma push strobe.
- dataChannel  in  2  target channel of the push.
- dataIn  in  WIDTH  push data.
- fullArray  out  4  per-channel full flags, to Rdma for flow control.
- emptyArray  out  4  per-channel empty flags.
- dataAvail  out  1  high when any channel holds data (~&emptyArray).

Behaviour:
- Reset (reset = 0, asynchronous):
  - all counts, read/write pointers and sticky bits cleared;
  - readdata = 0, emptyArray = 4'hF, fullArray = 4'h0, dataAvail = 0.
  - Reset mid-transfer discards all buffered data. No pop or push completes in the cycle reset deasserts unless sampled on a clock edge after deassertion.
- Access qualifier: acc = clken & chipselect. rd = acc & ~write. wr = acc & write.
- Push side:
  - Accepted when dataPush & ~fullArray[dataChannel]. Data is written at wptr[ch]; wptr increments modulo DEPTH; count[ch] increments.
  - Push to a full channel: data dropped, overrun[ch] set sticky.
  - fullArray[ch] = (count == DEPTH). emptyArray[ch] = (count == 0). Both are flag outputs decoded from registered counts.
- Data-window read (rd & ~address[9], ch = address[4:3]):
  - If ~empty[ch]: readdata <= mem[ch][rptr[ch]] on the next edge (latency 1). rptr increments modulo DEPTH; count decrements.
  - If empty[ch]: readdata <= 0; underrun[ch] set sticky; no pointer change.
  - address bits [8:5] and [2:0] are ignored.
- Status-window read (rd & address[9]): readdata <= status word, latency 1.
  - [3:0] empty, [7:4] full, [11:8] overrun, [15:12] underrun.
  - [19:16] count0, [23:20] count1, [27:24] count2, [31:28] count3.
  - All upper bits 0.
  - The word reflects pre-edge state.
- readdata holds its last value when no read is taken.
- Status-window write (wr & address[9] & byteenable[0]):
  - writedata[11:8] = 1 clears the matching overrun bits.
  - writedata[15:12] = 1 clears the matching underrun bits.
  - A set event in the same cycle as its clear wins (the bit stays 1).
- Writes to the data window are ignored.
- Simultaneous push and pop on the same channel:
  - Both occur; count is unchanged.
  - Full and empty are judged on pre-edge count. Push to a full channel is rejected even if a pop occurs the same cycle. Pop of an empty channel underruns even if a push occurs the same cycle (no bypass).
- Pointer wrap: a DEPTH-1 to 0 wrap must preserve FIFO order across any number of laps.
- Different channels push and pop independently in the same cycle.

Test Plan:
- Reset, then read status (address = 10'h200) -> readdata[31:0] = 32'h0000_000F. fullArray = 0, dataAvail = 0.
- Push 3 beats A, B, C to ch2, then 3 reads at address = 10'h010 -> readdata = A, B, C, each one cycle after its read. The 4th read returns 0 and sets underrun[2]; status = 32'h0000_400F.
- Push 9 beats D0..D8 to ch1 -> fullArray = 4'b0010 after the 8th beat. D8 is dropped; overrun[1] set. Reads at 10'h008 return D0..D7 only.
- Fill ch0 to 7, then push + pop ch0 in the same cycle -> count stays 7 and the popped value is the oldest. Fill to 8, then push + pop same cycle -> push rejected, count 7, overrun[0] = 1.
- Write 10'h200 with writedata[15:8] = 8'hFF, byteenable[0] = 1 -> sticky bits clear. Repeat with an overrun event in the same cycle -> that bit stays 1.
- Run 20 push/pop laps on ch3 with incrementing data -> strict in-order output across pointer wrap. Assert reset mid-stream -> emptyArray = 4'hF and readdata = 0 immediately.
